// File: rtl/uart_tx_feeder_if.sv
// Byte stream handshake between a producer and the UART transmit feeder.
// The producer drives data/valid; the feeder answers with ready.
interface uart_tx_feeder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus handshake sequencer feeding an 8N1 transmitter: one senddata
// pulse per byte, then waits for txdone to fall and rise before the next one.
module uart_tx_feeder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_tx_feeder_if.slave       in_if,
  output logic                  senddata,
  output logic [7:0]            txbyte,
  input  logic                  txdone,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW, WAIT_HIGH} state_t;

  state_t                state_q, state_d;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_q, rd_q;
  logic                  push, pop;

  assign in_if.in_ready = (count != FULL);
  assign push           = in_if.in_valid && in_if.in_ready;
  // A pop is exactly the IDLE->SEND transition; txdone guards against an in-flight frame.
  assign pop            = (state_q == IDLE) && (count != '0) && txdone;
  assign busy           = (count != '0) || (state_q != IDLE);

  // NOTE: every variable is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pop)     state_d = SEND;
      SEND:                   state_d = WAIT_LOW;
      WAIT_LOW:  if (!txdone) state_d = WAIT_HIGH;
      WAIT_HIGH: if (txdone)  state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      senddata <= 1'b0;
      txbyte   <= 8'h00;
      wr_q     <= '0;
      rd_q     <= '0;
      count    <= '0;
    end else begin
      state_q  <= state_d;
      senddata <= (state_d == SEND);
      if (pop) begin
        txbyte <= mem[rd_q];
        rd_q   <= rd_q + 1'b1;
      end
      if (push) wr_q <= wr_q + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= in_if.in_data;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized and directed bench for uart_tx_feeder with a behavioural
// transmitter, a byte scoreboard and an arithmetic occupancy model.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       senddata;
  logic [7:0] txbyte;
  logic       txdone;
  logic [4:0] count;
  logic       busy;

  uart_tx_feeder_if in_if ();

  uart_tx_feeder #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_if    (in_if),
    .senddata (senddata),
    .txbyte   (txbyte),
    .txdone   (txdone),
    .count    (count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_push = 0;
  int n_send = 0;
  int last_push_cyc = 0;
  logic [7:0] exp_q [$];
  int         send_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: txdone low from the cycle after a trigger for 11 cycles.
  int   tx_cnt = 0;
  logic tx_hold_low = 1'b0;
  always @(posedge clk) begin
    if (senddata)        tx_cnt <= 11;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end
  assign txdone = !tx_hold_low && (tx_cnt == 0);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pop on each trigger plus occupancy model checks.
  logic       sd_prev = 1'b0;
  logic       txdone_prev = 1'b1;
  logic [7:0] prev_txbyte = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (senddata) begin
        check("no_double_send", sd_prev, 1'b0);
        check("send_after_txdone", txdone_prev, 1'b1);
        check("send_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("txbyte_order", txbyte, exp_q.pop_front());
        n_send++;
        send_cyc.push_back(cyc);
      end else begin
        check("txbyte_hold", txbyte, prev_txbyte);
      end
      check("count", count, n_push - n_send);
      check("in_ready", in_if.in_ready, (n_push - n_send) != 16);
      if ((n_push - n_send) != 0 || senddata) check("busy", busy, 1'b1);
    end
    sd_prev     = rst_n ? senddata : 1'b0;
    prev_txbyte = rst_n ? txbyte : 8'h00;
    txdone_prev = txdone;
  end

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic push_byte(input logic [7:0] b);
    int   n = 0;
    logic acc = 1'b0;
    in_if.in_data  = b;
    in_if.in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_if.in_ready;
      if (acc) last_push_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 2000);
    in_if.in_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(b);
      n_push++;
    end else begin
      check("push_timeout", acc, 1'b1);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy == 1'b0 && exp_q.size() == 0 && txdone) && n < 3000);
    check(name, n < 3000, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_in_ready", in_if.in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_senddata", senddata, 1'b0);
    check("rst_txbyte", txbyte, 8'h00);
  endtask

  initial begin
    rst_n          = 1'b0;
    in_if.in_data  = 8'h00;
    in_if.in_valid = 1'b0;
    reset_checks();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte: trigger two cycles after the push.
    send_cyc.delete();
    push_byte(8'hA5);
    wait_idle("single_idle");
    check("single_sends", send_cyc.size(), 1);
    if (send_cyc.size() == 1) check("single_latency", send_cyc[0] - last_push_cyc, 2);
    check("single_busy_low", busy, 1'b0);

    // Burst: three pulses 14 cycles apart, including a simultaneous push/pop.
    send_cyc.delete();
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    wait_idle("burst_idle");
    check("burst_sends", send_cyc.size(), 3);
    if (send_cyc.size() == 3) begin
      check("burst_gap1", send_cyc[1] - send_cyc[0], 14);
      check("burst_gap2", send_cyc[2] - send_cyc[1], 14);
    end

    // Full: txdone held low, 16 accepted, 17th waits for the first pop.
    tx_hold_low = 1'b1;
    send_cyc.delete();
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    @(negedge clk);
    check("full_count", count, 16);
    check("full_ready", in_if.in_ready, 1'b0);
    @(posedge clk);
    #1;
    fork
      push_byte(8'h50);
      begin
        repeat (6) @(posedge clk);
        #1 tx_hold_low = 1'b0;
      end
    join
    check("full_pop_seen", send_cyc.size() > 0, 1'b1);
    if (send_cyc.size() > 0) check("full_17th_after_pop", last_push_cyc >= send_cyc[0], 1'b1);
    wait_idle("full_idle");
    check("full_sends", send_cyc.size(), 17);

    // Randomized traffic with random gaps.
    for (int i = 0; i < 40; i++) begin
      int gap = $urandom_range(0, 20);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      push_byte(8'($urandom));
    end
    wait_idle("random_idle");

    // Reset during WAIT_HIGH with five bytes queued.
    send_cyc.delete();
    for (int i = 0; i < 6; i++) push_byte(8'h10 + 8'(i));
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("midreset_queued", count, 5);
    check("midreset_in_flight", txdone, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    n_push = 0;
    n_send = 0;
    reset_checks();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_cyc.delete();
    push_byte(8'h3C);
    wait_idle("midreset_idle");
    check("midreset_sent_once", n_send, 1);

    // Empty idle: nothing must happen.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("empty_senddata", senddata, 1'b0);
      check("empty_busy", busy, 1'b0);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
